pma_checker: RTL

Runtime-programmable physical memory attribute checker with registered lookup, shared by the fetch and data bus interfaces of the core. It holds a table of address regions whose attributes are written at run time and can be locked. Each cycle it checks up to CHANNELS independent transfer requests against that table. Violations are captured in a sticky fault register with a saturating violation counter for trap handling and diagnostics.

---
 rtl/pma_checker.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pma_checker.sv
// Programmable PMA region table checking CHANNELS requests per cycle; sticky fault capture + saturating counter.
// Latency: 1 cycle request->response, fully pipelined, never stalls; table writes apply to the next cycle's requests.
module pma_checker #(
  parameter int PMA_REGIONS = 4,
  parameter int PMA_ALIGN   = 10,
  parameter int CHANNELS    = 2,
  parameter int CNT_WIDTH   = 8,
  parameter int IDX_W       = $clog2(PMA_REGIONS),
  parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   s_clk_i,
  input  logic                   s_reset_i,
  input  logic                   s_cfg_we_i,
  input  logic [IDX_W-1:0]       s_cfg_idx_i,
  input  logic [31:0]            s_cfg_base_i,
  input  logic [31:0]            s_cfg_mask_i,
  input  logic [4:0]             s_cfg_attr_i,
  output logic                   s_cfg_err_o,
  input  logic [CHANNELS-1:0]    s_req_i,
  input  logic [CHANNELS*32-1:0] s_address_i,
  input  logic [CHANNELS-1:0]    s_write_i,
  input  logic [CHANNELS-1:0]    s_fetch_i,
  output logic [CHANNELS-1:0]    s_rsp_o,
  output logic [CHANNELS-1:0]    s_idempotent_o,
  output logic [CHANNELS-1:0]    s_violation_o,
  output logic                   s_fault_o,
  output logic [31:0]            s_fault_addr_o,
  output logic [CH_W-1:0]        s_fault_ch_o,
  output logic [CNT_WIDTH-1:0]   s_fault_cnt_o,
  input  logic                   s_fault_clr_i
);

  localparam int A_LOCK  = 4;
  localparam int A_VALID = 3;
  localparam int A_EXEC  = 2;
  localparam int A_RO    = 1;
  localparam int A_IDEM  = 0;
  localparam int TAG_W   = 32 - PMA_ALIGN;
  localparam logic [4:0] ATTR_R0 = 5'b01101;

  logic [TAG_W-1:0] r_base [PMA_REGIONS];
  logic [TAG_W-1:0] r_mask [PMA_REGIONS];
  logic [4:0]       r_attr [PMA_REGIONS];
  logic             r_cfg_err;

  logic [CHANNELS-1:0]    r_rsp;
  logic [CHANNELS-1:0]    r_viol;
  logic [CHANNELS-1:0]    r_idem;
  logic [CHANNELS*32-1:0] r_addr;

  logic                 r_fault;
  logic [31:0]          r_fault_addr;
  logic [CH_W-1:0]      r_fault_ch;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic [4:0]           w_sel_attr [CHANNELS];
  logic [CHANNELS-1:0]  w_hit;
  logic [CHANNELS-1:0]  w_viol;
  logic [CHANNELS-1:0]  w_idem;
  logic                 w_any_viol;
  logic [CH_W-1:0]      w_cap_ch;
  logic [31:0]          w_cap_addr;
  logic [CNT_WIDTH-1:0] w_cnt_base;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_unused_cfg;

  assign w_unused_cfg = ^{s_cfg_base_i[PMA_ALIGN-1:0], s_cfg_mask_i[PMA_ALIGN-1:0]};

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      for (int i = 0; i < PMA_REGIONS; i++) begin
        r_base[i] <= '0;
        r_mask[i] <= '0;
        r_attr[i] <= (i == 0) ? ATTR_R0 : 5'b00000;
      end
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      if (s_cfg_we_i) begin
        if (r_attr[s_cfg_idx_i][A_LOCK]) begin
          r_cfg_err <= 1'b1;
        end else begin
          r_base[s_cfg_idx_i] <= s_cfg_base_i[31:PMA_ALIGN];
          r_mask[s_cfg_idx_i] <= s_cfg_mask_i[31:PMA_ALIGN];
          r_attr[s_cfg_idx_i] <= s_cfg_attr_i;
        end
      end
    end
  end

  // Scan from the top down so the lowest-index hitting region is the last to win.
  always_comb begin
    w_hit  = '0;
    w_viol = '0;
    w_idem = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_sel_attr[c] = '0;
      for (int r = PMA_REGIONS - 1; r >= 0; r--) begin
        if (r_attr[r][A_VALID] &&
            ((s_address_i[c*32+PMA_ALIGN +: TAG_W] & r_mask[r]) == r_base[r])) begin
          w_sel_attr[c] = r_attr[r];
          w_hit[c]      = 1'b1;
        end
      end
      w_viol[c] = !w_hit[c]
                | (s_fetch_i[c] & !w_sel_attr[c][A_EXEC])
                | (s_write_i[c] & w_sel_attr[c][A_RO]);
      w_idem[c] = w_sel_attr[c][A_IDEM];
    end
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      r_rsp  <= '0;
      r_viol <= '0;
      r_idem <= '0;
      r_addr <= '0;
    end else begin
      r_rsp  <= s_req_i;
      r_viol <= s_req_i & w_viol;
      r_idem <= s_req_i & w_idem;
      r_addr <= s_address_i;
    end
  end

  always_comb begin
    w_any_viol = |r_viol;
    w_cap_ch   = '0;
    w_cap_addr = '0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (r_viol[c]) begin
        w_cap_ch   = CH_W'(c);
        w_cap_addr = r_addr[c*32 +: 32];
      end
    end
    // Clear takes effect before a same-cycle violation is counted.
    w_cnt_base = s_fault_clr_i ? '0 : r_cnt;
    w_cnt_next = w_cnt_base;
    if (w_any_viol && (w_cnt_base != {CNT_WIDTH{1'b1}})) begin
      w_cnt_next = w_cnt_base + 1'b1;
    end
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
      r_fault_ch   <= '0;
      r_cnt        <= '0;
    end else begin
      if (s_fault_clr_i) begin
        r_fault      <= 1'b0;
        r_fault_addr <= '0;
        r_fault_ch   <= '0;
      end
      if ((!r_fault || s_fault_clr_i) && w_any_viol) begin
        r_fault      <= 1'b1;
        r_fault_addr <= w_cap_addr;
        r_fault_ch   <= w_cap_ch;
      end
      r_cnt <= w_cnt_next;
    end
  end

  assign s_cfg_err_o    = r_cfg_err;
  assign s_rsp_o        = r_rsp;
  assign s_violation_o  = r_viol;
  assign s_idempotent_o = r_idem;
  assign s_fault_o      = r_fault;
  assign s_fault_addr_o = r_fault_addr;
  assign s_fault_ch_o   = r_fault_ch;
  assign s_fault_cnt_o  = r_cnt;

endmodule
